apb_master_mux: RTL and testbench

//  Parametrised APB3 master plus slave mux: the next generation of the fixed 11-slot APB master.

---
 rtl/apb_pkg.sv | 31 +++
 rtl/apb_addr_decoder.sv | 34 +++
 rtl/apb_master_mux.sv | 171 +++++++++++++++++
 tb/tb_apb_master_mux.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 master/mux slice.
// Optional PREADY timeout is enabled by defining APB_TIMEOUT_EN.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DERR
   } apb_state_e;

   localparam int APB_DW = 32;
   localparam int APB_AW = 32;

   localparam logic [APB_DW-1:0] DECODE_ERR_DATA = 32'h0;
   localparam logic [APB_DW-1:0] TIMEOUT_DATA    = 32'hDEAD_BEEF;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Timeout counter is kept between 8 and 16 bits wide
   function automatic int tmo_width(input int t);
      int w;
      w = $clog2(t + 1);
      if (w < 8) w = 8;
      if (w > 16) w = 16;
      return w;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB window decoder: slot index, one-hot select and hit flag.
// Fixed-size slots of 2**SLV_AW bytes starting at BASE_ADDR.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int                NUM_SLV   = 11,
   parameter logic [APB_AW-1:0] BASE_ADDR = 32'h1000_0000,
   parameter int                SLV_AW    = 12,
   parameter int                TIMEOUT   = 255
) (
   input  logic [APB_AW-1:0]             addr,
   output logic [NUM_SLV-1:0]            sel,
   output logic [idx_width(NUM_SLV)-1:0] idx,
   output logic                          hit
);

   localparam int IW = idx_width(NUM_SLV);

   logic [APB_AW-1:0] off;
   logic [APB_AW-1:0] slot;

   assign off  = addr - BASE_ADDR;
   assign slot = off >> SLV_AW;
   assign hit  = (addr >= BASE_ADDR) && (slot < APB_AW'(NUM_SLV));
   assign idx  = slot[IW-1:0];

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         sel[i] = hit && (slot == APB_AW'(i));
      end
   end

endmodule

// File: rtl/apb_master_mux.sv
// Parametrised APB3 master with slave mux, decode-error response and
// optional PREADY timeout (define APB_TIMEOUT_EN).
module apb_master_mux
   import apb_pkg::*;
#(
   parameter int                NUM_SLV   = 11,
   parameter logic [APB_AW-1:0] BASE_ADDR = 32'h1000_0000,
   parameter int                SLV_AW    = 12,
   parameter int                TIMEOUT   = 255
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      transfer,
   input  logic                      write,
   input  logic [APB_AW-1:0]         addr,
   input  logic [APB_DW-1:0]         wdata,
   output logic                      ready,
   output logic [APB_DW-1:0]         rdata,
   output logic                      err,
   output logic [APB_AW-1:0]         PADDR,
   output logic [APB_DW-1:0]         PWDATA,
   output logic                      PWRITE,
   output logic                      PENABLE,
   output logic [NUM_SLV-1:0]        PSEL,
   input  logic [NUM_SLV*APB_DW-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]        PREADY,
   input  logic [NUM_SLV-1:0]        PSLVERR
);

   localparam int IW = idx_width(NUM_SLV);

   apb_state_e state_q, state_d;

   logic [NUM_SLV-1:0] dec_sel, sel_q;
   logic [IW-1:0]      dec_idx, idx_q;
   logic               dec_hit;

   logic [APB_AW-1:0] paddr_q;
   logic [APB_DW-1:0] pwdata_q;
   logic              pwrite_q;

   logic              ready_q, err_q;
   logic [APB_DW-1:0] rdata_q;

   logic              latch, done, done_err;
   logic [APB_DW-1:0] done_data;

   logic [APB_DW-1:0] prdata_sel;
   logic              pready_sel, pslverr_sel;

   apb_addr_decoder #(
      .NUM_SLV  (NUM_SLV),
      .BASE_ADDR(BASE_ADDR),
      .SLV_AW   (SLV_AW),
      .TIMEOUT  (TIMEOUT)
   ) u_dec (
      .addr(addr),
      .sel (dec_sel),
      .idx (dec_idx),
      .hit (dec_hit)
   );

   always_comb begin
      prdata_sel  = '0;
      pready_sel  = 1'b0;
      pslverr_sel = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == IW'(i)) begin
            prdata_sel  = PRDATA[i*APB_DW +: APB_DW];
            pready_sel  = PREADY[i];
            pslverr_sel = PSLVERR[i];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int TW = tmo_width(TIMEOUT);

   logic [TW-1:0] tcnt_q;
   logic          tmo_hit;

   // Abort at the end of the TIMEOUT-th not-ready ACCESS cycle
   assign tmo_hit = (tcnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         tcnt_q <= '0;
      end else if (state_q == SETUP) begin
         tcnt_q <= '0;
      end else if (state_q == ACCESS && !pready_sel) begin
         tcnt_q <= tcnt_q + TW'(1);
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      latch     = 1'b0;
      done      = 1'b0;
      done_err  = 1'b0;
      done_data = '0;
      unique case (state_q)
         IDLE: begin
            if (transfer) begin
               latch   = 1'b1;
               state_d = dec_hit ? SETUP : DERR;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (pready_sel) begin
               state_d   = IDLE;
               done      = 1'b1;
               done_data = pwrite_q ? '0 : prdata_sel;
               done_err  = pslverr_sel;
            end
`ifdef APB_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d   = IDLE;
               done      = 1'b1;
               done_data = TIMEOUT_DATA;
               done_err  = 1'b1;
            end
`endif
         end
         DERR: begin
            state_d   = IDLE;
            done      = 1'b1;
            done_data = DECODE_ERR_DATA;
            done_err  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         idx_q    <= '0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= done;
         rdata_q <= done_data;
         err_q   <= done_err;
         if (latch) begin
            sel_q    <= dec_sel;
            idx_q    <= dec_idx;
            paddr_q  <= addr;
            pwdata_q <= wdata;
            pwrite_q <= write;
         end
      end
   end

   assign PSEL    = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
   assign PENABLE = (state_q == ACCESS);
   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;
   assign PWRITE  = pwrite_q;
   assign ready   = ready_q;
   assign rdata   = rdata_q;
   assign err     = err_q;

endmodule

// File: tb/tb_apb_master_mux.sv
// Scoreboard bench for apb_master_mux: random transfers, behavioural slaves,
// directed cases for decode misses, PSLVERR, async reset and long waits.
module tb_apb_master_mux;

   localparam int          N    = 11;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          AW   = 12;
   localparam int          TO   = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          transfer = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   wdata = '0;
   logic          ready;
   logic [31:0]   rdata;
   logic          err;
   logic [31:0]   PADDR;
   logic [31:0]   PWDATA;
   logic          PWRITE;
   logic          PENABLE;
   logic [N-1:0]  PSEL;
   logic [N*32-1:0] PRDATA = '0;
   logic [N-1:0]  PREADY = '0;
   logic [N-1:0]  PSLVERR = '0;

   always #5 clk = ~clk;

   apb_master_mux #(
      .NUM_SLV  (N),
      .BASE_ADDR(BASE),
      .SLV_AW   (AW),
      .TIMEOUT  (TO)
   ) dut (
      .PCLK    (clk),
      .PRESET  (rst_n),
      .transfer(transfer),
      .write   (write),
      .addr    (addr),
      .wdata   (wdata),
      .ready   (ready),
      .rdata   (rdata),
      .err     (err),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PWRITE  (PWRITE),
      .PENABLE (PENABLE),
      .PSEL    (PSEL),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          setups;
      int          accs;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Current transaction as seen by the slave model and bus checker
   int          cur_idx = -1;
   int          cur_wait = 0;
   logic [31:0] cur_data = '0;
   logic        cur_err = 1'b0;
   logic [31:0] cur_addr = '0;
   logic [31:0] cur_wdata = '0;
   logic        cur_write = 1'b0;
   logic [N-1:0] cur_psel = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Behavioural slaves: target obeys its wait count, everything else is noise
   int acnt = 0;
   always @(negedge clk) begin
      if (PENABLE) acnt++;
      else acnt = 0;
      for (int i = 0; i < N; i++) begin
         if (i == cur_idx) begin
            PRDATA[i*32 +: 32] = cur_data;
            PSLVERR[i] = cur_err;
            PREADY[i] = PENABLE ? (acnt > cur_wait) : 1'($urandom_range(0, 1));
         end else begin
            PRDATA[i*32 +: 32] = $urandom;
            PSLVERR[i] = 1'($urandom_range(0, 1));
            PREADY[i] = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: bus checks during a transfer, scoreboard pop on ready
   int m_setups = 0;
   int m_accs = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         m_setups = 0;
         m_accs = 0;
      end else begin
         if (PSEL != '0) begin
            chk("psel", 32'(PSEL), 32'(cur_psel));
            chk("paddr", PADDR, cur_addr);
            chk("pwrite", 32'(PWRITE), 32'(cur_write));
            chk("pwdata", PWDATA, cur_wdata);
            if (PENABLE) m_accs++;
            else m_setups++;
         end
         if (ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_ready: got ready=1 want no completion");
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rdata", rdata, e.rdata);
               chk("err", 32'(err), 32'(e.err));
               chk("setup_cycles", 32'(m_setups), 32'(e.setups));
               chk("access_cycles", 32'(m_accs), 32'(e.accs));
            end
            m_setups = 0;
            m_accs = 0;
         end
      end
   end

   function automatic logic is_hit(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) >> AW) < 32'(N));
   endfunction

   // Called at posedge+1; returns at posedge+1 of the ready cycle
   task automatic xfer(input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input int wt,
                       input logic [31:0] d, input logic e);
      exp_t ex;
      logic h;
      int   slot;
      int   edges;
      bit   seen;
      h = is_hit(a);
      slot = h ? int'((a - BASE) >> AW) : -1;
      cur_idx = slot;
      cur_wait = wt;
      cur_data = d;
      cur_err = e;
      cur_addr = a;
      cur_wdata = wd;
      cur_write = w;
      cur_psel = h ? (N'(1) << slot) : '0;
      if (!h) begin
         ex.rdata = 32'h0;
         ex.err = 1'b1;
         ex.setups = 0;
         ex.accs = 0;
      end else begin
         ex.setups = 1;
         ex.accs = wt + 1;
         ex.rdata = w ? 32'h0 : d;
         ex.err = e;
`ifdef APB_TIMEOUT_EN
         if (wt + 1 > TO) begin
            ex.accs = TO;
            ex.rdata = 32'hDEAD_BEEF;
            ex.err = 1'b1;
         end
`endif
      end
      sb.push_back(ex);
      addr = a;
      write = w;
      wdata = wd;
      transfer = 1'b1;
      edges = 0;
      seen = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         edges++;
         if (ready) begin
            seen = 1;
            break;
         end
      end
      transfer = 1'b0;
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got no ready want ready for %h", a);
      end else begin
         chk("latency", 32'(edges), 32'(h ? 2 + ex.accs : 2));
      end
   endtask

   task automatic reset_mid;
      cur_idx = 4;
      cur_wait = 100000;
      cur_data = 32'h1234_5678;
      cur_err = 1'b0;
      cur_addr = BASE + 32'h4000;
      cur_wdata = 32'h0;
      cur_write = 1'b0;
      cur_psel = N'(1) << 4;
      addr = cur_addr;
      wdata = 32'h0;
      write = 1'b0;
      transfer = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_penable", 32'(PENABLE), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_psel", 32'(PSEL), 32'd0);
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      transfer = 1'b0;
      cur_idx = -1;
      cur_psel = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got hang want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      #12;
      chk("rst_psel0", 32'(PSEL), 32'd0);
      chk("rst_penable0", 32'(PENABLE), 32'd0);
      chk("rst_ready0", 32'(ready), 32'd0);
      chk("rst_err0", 32'(err), 32'd0);
      chk("rst_rdata0", rdata, 32'd0);
      chk("rst_paddr0", PADDR, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      xfer(32'h1000_3004, 1'b0, 32'h0, 0, 32'hA5A5_0003, 1'b0);
      xfer(32'h1000_6000, 1'b1, 32'h55, 4, 32'hFFFF_FFFF, 1'b0);
      xfer(32'h1000_B000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
      xfer(32'h0FFF_FFFC, 1'b0, 32'h0, 0, 32'h0, 1'b0);
      xfer(32'h1000_2010, 1'b0, 32'h0, 1, 32'hCAFE_0002, 1'b1);
      xfer(32'h1000_2014, 1'b0, 32'h0, 0, 32'h0BAD_0002, 1'b0);
      xfer(32'h1000_A000, 1'b1, 32'hFEED_000A, 2, 32'h0, 1'b0);

      reset_mid();
      xfer(32'h1000_1008, 1'b0, 32'h0, 0, 32'h1111_0001, 1'b0);

      xfer(32'h1000_5000, 1'b0, 32'h0, 1000, 32'h5555_0005, 1'b0);
      xfer(32'h1000_0000, 1'b0, 32'h0, 0, 32'h0000_0A00, 1'b0);

      for (int t = 0; t < 150; t++) begin
         int k;
         k = $urandom_range(0, 9);
         if (k == 0) begin
            if ($urandom_range(0, 1) == 1)
               a = BASE - 32'($urandom_range(1, 4000));
            else
               a = BASE + 32'(N << AW) + 32'($urandom_range(0, 32'hF_FFFF));
         end else begin
            a = BASE + 32'($urandom_range(0, N - 1) << AW)
                     + 32'($urandom_range(0, 1023) << 2);
         end
         xfer(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5),
              $urandom, ($urandom_range(0, 7) == 0));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (5) @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
